tetris_field_render: RTL and testbench

Pipelined renderer for one rectangular brick field: maps the current VGA pixel to a field cell and returns its 24-bit colour after exactly 3 clocks. It generalises our fixed-size field drawing to any size and geometry. It adds a runtime origin, a runtime palette and a frame-synchronous row-flash animation used when lines are cleared. One instance per on-screen field; the main field and the next-block preview use separate instances, and the top-level mux picks the first instance with `vga_data_en_o` set.

---
 rtl/tetris_field_render.sv | 185 ++++++++++++++++++
 tb/tb_tetris_field_render.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tetris_field_render.sv
// rtl/tetris_field_render.sv - three-stage brick field renderer with runtime origin, palette and row flash
module tetris_field_render #(
  parameter int          PIX_WIDTH     = 12,
  parameter int          COL_CNT       = 10,
  parameter int          ROW_CNT       = 20,
  parameter int          COLOR_W       = 3,
  parameter int          BRICK_X       = 30,
  parameter int          BRICK_Y       = 30,
  parameter int          BORDER_X      = 2,
  parameter int          BORDER_Y      = 2,
  parameter int          START_X       = 300,
  parameter int          START_Y       = 200,
  parameter int          FLASH_FRAMES  = 8,
  parameter int          FLASH_TOGGLES = 6,
  parameter logic [23:0] FLASH_COLOR   = 24'hFFFFFF
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [PIX_WIDTH-1:0]                pix_x_i,
  input  logic [PIX_WIDTH-1:0]                pix_y_i,
  input  logic                                pix_valid_i,
  input  logic                                frame_start_i,
  input  logic [PIX_WIDTH-1:0]                start_x_i,
  input  logic [PIX_WIDTH-1:0]                start_y_i,
  input  logic [ROW_CNT*COL_CNT*COLOR_W-1:0]  field_i,
  input  logic [(2**COLOR_W)*24-1:0]          palette_i,
  input  logic [23:0]                         border_color_i,
  input  logic [ROW_CNT-1:0]                  flash_rows_i,
  input  logic                                flash_start_i,
  output logic                                flash_busy_o,
  output logic                                flash_done_o,
  output logic [23:0]                         vga_data_o,
  output logic                                vga_data_en_o,
  output logic                                vga_valid_o
);
  localparam int PITCH_X = BRICK_X + BORDER_X;
  localparam int PITCH_Y = BRICK_Y + BORDER_Y;
  localparam int FIELD_W = COL_CNT * PITCH_X + BORDER_X;
  localparam int FIELD_H = ROW_CNT * PITCH_Y + BORDER_Y;
  localparam int COL_W   = $clog2(COL_CNT + 1);
  localparam int ROW_W   = $clog2(ROW_CNT + 1);
  localparam int FC_W    = $clog2(FLASH_FRAMES + 1);
  localparam int TC_W    = $clog2(FLASH_TOGGLES + 1);

  typedef logic signed [PIX_WIDTH:0] delta_t;
  typedef enum logic {IDLE, FLASH} state_t;

  state_t               state;
  logic [PIX_WIDTH-1:0] org_x, org_y;
  logic [ROW_CNT-1:0]   flash_mask;
  logic                 flash_phase;
  logic [FC_W-1:0]      frame_cnt;
  logic [TC_W-1:0]      tog_cnt;

  delta_t               s1_dx, s1_dy;
  logic                 s1_in_x, s1_in_y, s1_valid;
  logic [COL_W-1:0]     s2_col;
  logic [ROW_W-1:0]     s2_row;
  logic                 s2_in_brick, s2_in_field, s2_flash, s2_valid;

  delta_t               dx_c, dy_c;
  logic [PIX_WIDTH-1:0] ux, uy, col_c, row_c, mod_x, mod_y;
  logic                 brick_x, brick_y;
  logic [ROW_CNT-1:0]   mask_sel;
  logic [COLOR_W-1:0]   cidx;
  logic [23:0]          pal_c;

  assign dx_c = $signed({1'b0, pix_x_i}) - $signed({1'b0, org_x});
  assign dy_c = $signed({1'b0, pix_y_i}) - $signed({1'b0, org_y});
  assign flash_busy_o = (state == FLASH);

  // Once S1 says the pixel is in range the delta is non-negative, so its low bits are the magnitude.
  always_comb begin
    ux       = s1_dx[PIX_WIDTH-1:0];
    uy       = s1_dy[PIX_WIDTH-1:0];
    col_c    = ux / PIX_WIDTH'(PITCH_X);
    row_c    = uy / PIX_WIDTH'(PITCH_Y);
    mod_x    = ux % PIX_WIDTH'(PITCH_X);
    mod_y    = uy % PIX_WIDTH'(PITCH_Y);
    brick_x  = s1_in_x && (mod_x >= PIX_WIDTH'(BORDER_X)) && (col_c < PIX_WIDTH'(COL_CNT));
    brick_y  = s1_in_y && (mod_y >= PIX_WIDTH'(BORDER_Y)) && (row_c < PIX_WIDTH'(ROW_CNT));
    mask_sel = flash_mask >> row_c;
  end

  always_comb begin
    cidx = '0;
    if (s2_in_brick)
      cidx = field_i[(int'(s2_row) * COL_CNT + int'(s2_col)) * COLOR_W +: COLOR_W];
    pal_c = palette_i[int'(cidx) * 24 +: 24];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_dx         <= '0;
      s1_dy         <= '0;
      s1_in_x       <= 1'b0;
      s1_in_y       <= 1'b0;
      s1_valid      <= 1'b0;
      s2_col        <= '0;
      s2_row        <= '0;
      s2_in_brick   <= 1'b0;
      s2_in_field   <= 1'b0;
      s2_flash      <= 1'b0;
      s2_valid      <= 1'b0;
      vga_data_o    <= '0;
      vga_data_en_o <= 1'b0;
      vga_valid_o   <= 1'b0;
    end else begin
      s1_dx    <= dx_c;
      s1_dy    <= dy_c;
      s1_in_x  <= !dx_c[PIX_WIDTH] && (dx_c < delta_t'(FIELD_W));
      s1_in_y  <= !dy_c[PIX_WIDTH] && (dy_c < delta_t'(FIELD_H));
      s1_valid <= pix_valid_i;

      s2_col      <= COL_W'(col_c);
      s2_row      <= ROW_W'(row_c);
      s2_in_brick <= brick_x && brick_y;
      s2_in_field <= s1_in_x && s1_in_y;
      s2_flash    <= brick_x && brick_y && flash_phase && mask_sel[0];
      s2_valid    <= s1_valid;

      vga_valid_o   <= s2_valid;
      vga_data_en_o <= s2_in_field;
      if (!s2_in_field)
        vga_data_o <= '0;
      else if (!s2_in_brick)
        vga_data_o <= border_color_i;
      else if (s2_flash)
        vga_data_o <= FLASH_COLOR;
      else
        vga_data_o <= pal_c;
    end
  end

  // Origin only moves on frame boundaries; the final toggle ends the sequence on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      org_x        <= PIX_WIDTH'(START_X);
      org_y        <= PIX_WIDTH'(START_Y);
      flash_mask   <= '0;
      flash_phase  <= 1'b0;
      frame_cnt    <= '0;
      tog_cnt      <= '0;
      flash_done_o <= 1'b0;
    end else begin
      flash_done_o <= 1'b0;
      if (frame_start_i) begin
        org_x <= start_x_i;
        org_y <= start_y_i;
      end
      case (state)
        IDLE: begin
          if (flash_start_i) begin
            state       <= FLASH;
            flash_mask  <= flash_rows_i;
            flash_phase <= 1'b1;
            frame_cnt   <= '0;
            tog_cnt     <= '0;
          end
        end
        FLASH: begin
          if (frame_start_i) begin
            if (frame_cnt == FC_W'(FLASH_FRAMES - 1)) begin
              frame_cnt <= '0;
              if (tog_cnt == TC_W'(FLASH_TOGGLES - 1)) begin
                state        <= IDLE;
                flash_mask   <= '0;
                flash_phase  <= 1'b0;
                tog_cnt      <= '0;
                flash_done_o <= 1'b1;
              end else begin
                flash_phase <= ~flash_phase;
                tog_cnt     <= tog_cnt + 1'b1;
              end
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tetris_field_render.sv
// tb/tb_tetris_field_render.sv - directed and streamed checks of tetris_field_render
module tb_tetris_field_render;
  localparam int PW = 12;
  localparam int CC = 10;
  localparam int RC = 20;
  localparam int CW = 3;
  localparam logic [23:0] BORDER = 24'h123456;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [PW-1:0]       pix_x, pix_y, start_x, start_y;
  logic                pix_valid, frame_start, flash_start;
  logic [RC*CC*CW-1:0] field;
  logic [8*24-1:0]     palette;
  logic [23:0]         border_color;
  logic [RC-1:0]       flash_rows;
  logic                flash_busy, flash_done, vga_en, vga_valid;
  logic [23:0]         vga_data;

  int checks = 0;
  int failures = 0;
  logic [25:0] exp_q[$];
  logic [25:0] exp_v;
  logic [24:0] m;

  tetris_field_render #(.FLASH_FRAMES(2), .FLASH_TOGGLES(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .pix_x_i(pix_x), .pix_y_i(pix_y), .pix_valid_i(pix_valid),
    .frame_start_i(frame_start), .start_x_i(start_x), .start_y_i(start_y),
    .field_i(field), .palette_i(palette), .border_color_i(border_color),
    .flash_rows_i(flash_rows), .flash_start_i(flash_start),
    .flash_busy_o(flash_busy), .flash_done_o(flash_done),
    .vga_data_o(vga_data), .vga_data_en_o(vga_en), .vga_valid_o(vga_valid)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick3();
    repeat (3) tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    pix_x = PW'(x);
    pix_y = PW'(y);
  endtask

  function automatic logic [24:0] model(input int x, input int y, input int ox, input int oy);
    int dx, dy, c, r, k;
    logic bx, by;
    dx = x - ox;
    dy = y - oy;
    if (dx < 0 || dy < 0 || dx >= 322 || dy >= 642) return 25'd0;
    c  = dx / 32;
    r  = dy / 32;
    bx = (dx % 32 >= 2) && (c < 10);
    by = (dy % 32 >= 2) && (r < 20);
    if (!(bx && by)) return {1'b1, border_color};
    k = int'(field[(r * 10 + c) * 3 +: 3]);
    return {1'b1, palette[k * 24 +: 24]};
  endfunction

  initial begin
    rst = 1'b1;
    pix_x = '0; pix_y = '0; pix_valid = 1'b0;
    frame_start = 1'b0; flash_start = 1'b0;
    start_x = 12'd300; start_y = 12'd200;
    flash_rows = '0;
    border_color = BORDER;
    for (int i = 0; i < RC * CC; i++) field[i*3 +: 3] = 3'($urandom_range(7, 0));
    field[0 +: 3] = 3'd3;
    field[(19 * 10) * 3 +: 3] = 3'd5;
    for (int k = 0; k < 8; k++) palette[k*24 +: 24] = {8'(k * 30), 8'(255 - k * 20), 8'(k * 7 + 1)};
    palette[3*24 +: 24] = 24'h00FF00;
    palette[5*24 +: 24] = 24'hC0FFEE;

    repeat (3) tick();
    check("rst_data", vga_data, 0);
    check("rst_en", vga_en, 0);
    check("rst_valid", vga_valid, 0);
    check("rst_busy", flash_busy, 0);
    check("rst_done", flash_done, 0);
    rst = 1'b0;
    tick();

    frame();
    pix_valid = 1'b1;
    pix(302, 202); tick3();
    check("cell00_data", vga_data, 24'h00FF00);
    check("cell00_en", vga_en, 1);
    check("cell00_valid", vga_valid, 1);
    pix(300, 200); tick3();
    check("corner_border", {vga_en, vga_data}, {1'b1, BORDER});
    pix(622, 300); tick3();
    check("right_out", {vga_en, vga_data}, 25'd0);
    pix(299, 300); tick3();
    check("left_out", {vga_en, vga_data}, 25'd0);
    pix(621, 841); tick3();
    check("far_corner", {vga_en, vga_data}, {1'b1, BORDER});
    pix_valid = 1'b0;
    pix(302, 202); tick3();
    check("invalid_pix", vga_valid, 0);
    pix_valid = 1'b1;

    start_x = 12'd100;
    pix(102, 202); tick3();
    check("org_hold", {vga_en, vga_data}, 25'd0);
    frame(); tick3();
    check("org_moved", {vga_en, vga_data}, {1'b1, 24'h00FF00});
    start_x = 12'd300;
    frame();

    pix(307, 815);
    flash_rows = 20'h80000;
    flash_start = 1'b1; tick(); flash_start = 1'b0;
    check("flash_busy0", flash_busy, 1);
    tick3();
    check("flash_lit0", vga_data, 24'hFFFFFF);
    for (int k = 1; k <= 8; k++) begin
      frame();
      check($sformatf("flash_done_%0d", k), flash_done, (k == 8));
      if (k == 1) begin
        flash_rows = '0;
        flash_start = 1'b1; tick(); flash_start = 1'b0;
      end
      tick3();
      check($sformatf("flash_col_%0d", k), vga_data,
            (k < 8 && ((k / 2) % 2 == 0)) ? 24'hFFFFFF : 24'hC0FFEE);
      check($sformatf("flash_busy_%0d", k), flash_busy, (k < 8));
    end
    check("done_cleared", flash_done, 0);

    flash_rows = 20'h80000;
    flash_start = 1'b1; frame_start = 1'b1; tick();
    flash_start = 1'b0; frame_start = 1'b0;
    tick3();
    check("coinc_lit", vga_data, 24'hFFFFFF);
    frame(); tick3();
    check("coinc_not_counted", vga_data, 24'hFFFFFF);
    frame(); tick3();
    check("coinc_toggle", vga_data, 24'hC0FFEE);

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", flash_busy, 0);
    check("arst_done", flash_done, 0);
    check("arst_out", {vga_valid, vga_en, vga_data}, 26'd0);
    tick();
    check("arst_done_hold", flash_done, 0);
    rst = 1'b0;
    tick();
    check("post_rst_done", flash_done, 0);

    for (int n = 0; n < 200; n++) begin
      pix(int'($urandom_range(680, 250)), int'($urandom_range(900, 150)));
      pix_valid = 1'($urandom_range(1, 0));
      m = model(int'(pix_x), int'(pix_y), 300, 200);
      exp_q.push_back({pix_valid, m});
      tick();
      if (exp_q.size() == 3) begin
        exp_v = exp_q.pop_front();
        check("stream", {vga_valid, vga_en, vga_data}, exp_v);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
